// File: rtl/mux16_rr_arbiter.sv
// Shares one registered WIDTH-bit output path between NREQ requesters, with round-robin
// arbitration and a bounded bus-lock. Define MUX16_ARB_FIXED_PRIO_EN for fixed priority.
module mux16_rr_arbiter #(
   parameter int NREQ     = 4,
   parameter int WIDTH    = 16,
   parameter int HOLD_MAX = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*WIDTH-1:0]     data_in,
   output logic [NREQ-1:0]           gnt,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data,
   output logic [$clog2(NREQ)-1:0]   out_id
);

   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(HOLD_MAX + 1);
   localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);

   typedef enum logic {
      ST_IDLE,
      ST_OWN
   } state_t;

   typedef struct packed {
      logic           found;
      logic [IDW-1:0] idx;
   } pick_t;

   // First set bit of mask, scanning upward from start and wrapping at NREQ.
   function automatic pick_t arb_pick(input logic [NREQ-1:0] mask,
                                      input logic [IDW-1:0]  start);
      pick_t r;
      int    idx;
      r = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(start) + k) % NREQ;
         if (!r.found && mask[idx]) begin
            r.found = 1'b1;
            r.idx   = IDW'(idx);
         end
      end
      return r;
   endfunction

   function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] i);
      return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
   endfunction

   state_t               state_q, state_d;
   logic [IDW-1:0]       owner_q, owner_d;
   logic [IDW-1:0]       ptr_q, ptr_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [NREQ-1:0]      gnt_q, gnt_d;
   logic                 out_valid_q, out_valid_d;
   logic [WIDTH-1:0]     out_data_q, out_data_d;
   logic [IDW-1:0]       out_id_q, out_id_d;

   logic [NREQ-1:0]      owner_mask;
   logic                 own_req;
   logic [WIDTH-1:0]     sel_data;
   pick_t                win;
   logic                 take;

   assign owner_mask = NREQ'(1) << owner_q;
   assign own_req    = |(req & owner_mask);

   // Select fabric: route the current owner's data word toward the output register.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (owner_q == IDW'(i)) sel_data = data_in[i*WIDTH +: WIDTH];
      end
   end

   // NOTE: every signal gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      win     = '0;
      take    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            win  = arb_pick(req, ptr_q);
            take = win.found;
         end
         ST_OWN: begin
            if (!own_req) begin
               win  = arb_pick(req, ptr_q);
               take = win.found;
               if (!win.found) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            end else if (cnt_q < HOLD_LIM) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               // Hold limit reached: owner yields only if someone else is waiting.
               win  = arb_pick(req & ~owner_mask, ptr_q);
               take = win.found;
               if (!win.found) cnt_d = CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (take) begin
         state_d = ST_OWN;
         owner_d = win.idx;
         cnt_d   = CW'(1);
`ifdef MUX16_ARB_FIXED_PRIO_EN
         ptr_d   = '0;
`else
         ptr_d   = wrap_inc(win.idx);
`endif
      end

      gnt_d = (state_d == ST_OWN) ? (NREQ'(1) << owner_d) : '0;
   end

   // Output word reflects the grant that was live at the edge, if its owner still requested.
   always_comb begin
      out_valid_d = |(gnt_q & req);
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;
      if (out_valid_d) begin
         out_data_d = sel_data;
         out_id_d   = owner_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         owner_q     <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
         gnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
      end
   end

   assign gnt       = gnt_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Bench for mux16_rr_arbiter: directed steps plus random traffic checked against an
// ownership-level reference model. Honours MUX16_ARB_FIXED_PRIO_EN like the design.
module tb_mux16_rr_arbiter;

   localparam int NREQ     = 4;
   localparam int WIDTH    = 16;
   localparam int HOLD_MAX = 8;

   logic                  clk;
   logic                  rst_n;
   logic [NREQ-1:0]       req;
   logic [WIDTH-1:0]      data_arr [NREQ];
   logic [NREQ*WIDTH-1:0] data_in;
   logic [NREQ-1:0]       gnt;
   logic                  out_valid;
   logic [WIDTH-1:0]      out_data;
   logic [1:0]            out_id;

   int total = 0;
   int bad   = 0;

   // Reference model: who owns the path, for how long, and where the search starts.
   int               m_owner;
   int               m_cnt;
   int               m_ptr;
   logic [NREQ-1:0]  exp_gnt;
   logic             exp_valid;
   logic [WIDTH-1:0] exp_data;
   logic [1:0]       exp_id;

   mux16_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD_MAX(HOLD_MAX)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .data_in   (data_in),
      .gnt       (gnt),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_id    (out_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      data_in = '0;
      for (int i = 0; i < NREQ; i++) data_in[i*WIDTH +: WIDTH] = data_arr[i];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] r, input int excl, input int start);
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (start + k) % NREQ;
         if (r[idx] && idx != excl) return idx;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner   = -1;
      m_cnt     = 0;
      m_ptr     = 0;
      exp_gnt   = '0;
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_id    = '0;
   endtask

   task automatic model_grant(input int w);
      m_owner = w;
      m_cnt   = 1;
`ifdef MUX16_ARB_FIXED_PRIO_EN
      m_ptr   = 0;
`else
      m_ptr   = (w + 1) % NREQ;
`endif
   endtask

   // Advance the model across one rising edge using the inputs currently applied.
   task automatic model_step();
      int w;
      int start;
`ifdef MUX16_ARB_FIXED_PRIO_EN
      start = 0;
`else
      start = m_ptr;
`endif
      exp_valid = (m_owner >= 0) ? req[m_owner] : 1'b0;
      if (exp_valid) begin
         exp_data = data_arr[m_owner];
         exp_id   = m_owner[1:0];
      end
      if (m_owner < 0) begin
         w = pick(req, -1, start);
         if (w >= 0) model_grant(w);
      end else if (!req[m_owner]) begin
         w = pick(req, -1, start);
         if (w >= 0) model_grant(w);
         else begin
            m_owner = -1;
            m_cnt   = 0;
         end
      end else if (m_cnt < HOLD_MAX) begin
         m_cnt++;
      end else begin
         w = pick(req, m_owner, start);
         if (w >= 0) model_grant(w);
         else m_cnt = 1;
      end
      exp_gnt = (m_owner < 0) ? '0 : (NREQ'(1) << m_owner);
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check("gnt", 32'(gnt), 32'(exp_gnt));
      check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      check("out_data", 32'(out_data), 32'(exp_data));
      check("out_id", 32'(out_id), 32'(exp_id));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      rst_n = 1'b0;
      req   = '0;
      for (int i = 0; i < NREQ; i++) data_arr[i] = '0;
      model_reset();
      #12;
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_id", 32'(out_id), 32'd0);
      rst_n = 1'b1;

      // Idle with no requests.
      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < NREQ; j++) data_arr[j] = WIDTH'($urandom);
         cycle();
         check("idle_gnt", 32'(gnt), 32'd0);
         check("idle_valid", 32'(out_valid), 32'd0);
         check("idle_data", 32'(out_data), 32'h0000);
      end

      // Two requesters; owner 0 drops and requester 2 takes over without a dead cycle.
      req = 4'b0101;
      data_arr[0] = 16'h0001;
      data_arr[2] = 16'h1232;
      cycle();
      check("dir_gnt0", 32'(gnt), 32'b0001);
      cycle();
      check("dir_valid0", 32'(out_valid), 32'd1);
      check("dir_data0", 32'(out_data), 32'h0001);
      check("dir_id0", 32'(out_id), 32'd0);
      req = 4'b0100;
      cycle();
      check("dir_gnt2", 32'(gnt), 32'b0100);
      cycle();
      check("dir_data2", 32'(out_data), 32'h1232);
      check("dir_id2", 32'(out_id), 32'd2);
      req = 4'b0000;
      cycle();
      cycle();
      check("dir_idle", 32'(gnt), 32'd0);

      // Hold-limit rotation from a fresh pointer.
      do_reset();
`ifdef MUX16_ARB_FIXED_PRIO_EN
      req = 4'b0110;
      for (int k = 0; k < 3 * HOLD_MAX; k++) begin
         cycle();
         check("fixed_rot", 32'(gnt), ((k / HOLD_MAX) % 2 == 0) ? 32'b0010 : 32'b0100);
      end
`else
      req = 4'b1111;
      for (int k = 0; k < 5 * HOLD_MAX; k++) begin
         cycle();
         check("rr_rot", 32'(gnt), 32'(1) << ((k / HOLD_MAX) % NREQ));
      end
`endif

      // Lone requester keeps the path across the hold limit with no output gap.
      req = 4'b0010;
      for (int k = 0; k < 20; k++) begin
         data_arr[1] = WIDTH'($urandom);
         cycle();
         check("lone_gnt", 32'(gnt), 32'b0010);
         if (k > 0) check("lone_valid", 32'(out_valid), 32'd1);
      end

      // Asynchronous reset mid-ownership, then pointer restarts at 0.
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_gnt", 32'(gnt), 32'd0);
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_data", 32'(out_data), 32'd0);
      model_reset();
      #2;
      rst_n = 1'b1;
      req   = 4'b1000;
      cycle();
      check("arst_regnt", 32'(gnt), 32'b1000);

      // Random traffic: requests persist with occasional toggles.
      for (int n = 0; n < 400; n++) begin
         for (int j = 0; j < NREQ; j++) begin
            if ($urandom_range(3) == 0) req[j] = ~req[j];
            data_arr[j] = WIDTH'($urandom);
         end
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
